// File: rtl/pipelined_barrel_shifter_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter_pkg
//
// Shared definitions for the pipelined barrel shifter:
//   - shift_mode_e : operating mode encodings carried down the pipeline
//   - DIR_LEFT / DIR_RIGHT : values of the direction control bit
//   - bit_reverse  : mirrors the low w bits of a vector. Left shifts are
//                    done as right shifts on a mirrored operand, so this is
//                    applied before the first stage and after the last one.
// ---------------------------------------------------------------------------
package pipelined_barrel_shifter_pkg;

    // Widest operand bit_reverse can handle; operands are zero-extended to
    // this width on the way in and sliced back down on the way out.
    localparam int MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } shift_mode_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Bit i of the result takes bit (w-1-i) of d for i < w; higher bits are 0.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(
        input logic [MAX_WIDTH-1:0] d,
        input int                   w
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                r[i] = d[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//
// One registered level of the barrel shifter. It conditionally shifts its
// operand right by DIST bits and registers the result together with the
// control fields that later stages still need.
//
// The active shift-amount bit is always the MSB of src_shamt. The registered
// copy is shifted left by one so the next stage again finds its own bit in
// the MSB position; consumed bits fall off the top.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears valid only)
//   en              global pipeline enable; when low every register holds
//   src_*           fields from the previous stage (or the input conditioner)
//   stage_*         registered fields presented to the next stage
// ---------------------------------------------------------------------------
module shift_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] src_data,
    input  logic [SHW-1:0]   src_shamt,
    input  logic             src_dir,
    input  logic [1:0]       src_mode,
    input  logic             src_fill,
    input  logic             src_valid,
    output logic [WIDTH-1:0] stage_data,
    output logic [SHW-1:0]   stage_shamt,
    output logic             stage_dir,
    output logic [1:0]       stage_mode,
    output logic             stage_fill,
    output logic             stage_valid
);

    logic [WIDTH-1:0] shifted;

    // Right shift by DIST when this stage's shift bit is set. Rotate wraps
    // the bits leaving the LSB end back into the top; every other mode
    // (including the reserved one) fills the vacated top bits with the fill
    // bit, which is the sign only for arithmetic right shifts.
    always_comb begin
        shifted = src_data;
        if (src_shamt[SHW-1]) begin
            if (src_mode == MODE_ROTATE) begin
                shifted = {src_data[DIST-1:0], src_data[WIDTH-1:DIST]};
            end else begin
                shifted = {{DIST{src_fill}}, src_data[WIDTH-1:DIST]};
            end
        end
    end

    // Valid is the only state that must be cleared by reset so that any
    // in-flight operation disappears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
        end else if (en) begin
            stage_valid <= src_valid;
        end
    end

    // Payload registers are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            stage_data  <= shifted;
            stage_shamt <= {src_shamt[SHW-2:0], 1'b0};
            stage_dir   <= src_dir;
            stage_mode  <= src_mode;
            stage_fill  <= src_fill;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined bidirectional shifter supporting logical, arithmetic and rotate
// modes over a WIDTH-bit operand (WIDTH a power of two, at least 4).
// There is one register level per shift-amount bit, largest distance first.
// Left shifts are executed as right shifts on a bit-reversed operand, which
// is mirrored back on the way out.
//
// The whole pipeline moves together: it advances whenever the output slot is
// empty or being drained, and otherwise every stage holds. Bubbles are not
// squeezed out. A result appears SHW rising edges after it is presented,
// counting the edge that accepts it.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand and controls presented this cycle
//   in_ready   pipeline can accept an operand this cycle
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_dir     1 = left, 0 = right
//   in_mode    00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   shifted result (0 while out_valid is low)
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index 0 is the conditioned input; index k+1 is the output of stage k.
    logic [WIDTH-1:0] st_data  [SHW+1];
    logic [SHW-1:0]   st_shamt [SHW+1];
    logic             st_dir   [SHW+1];
    logic [1:0]       st_mode  [SHW+1];
    logic             st_fill  [SHW+1];
    logic             st_valid [SHW+1];

    logic                 en;
    logic [MAX_WIDTH-1:0] in_rev_full;
    logic [MAX_WIDTH-1:0] out_rev_full;
    logic [WIDTH-1:0]     result;

    // The output slot is free when empty or being drained this cycle; that
    // single condition gates every stage.
    assign out_valid = st_valid[SHW];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    // Mirror left-shift operands so all stages only ever shift right. Only
    // an arithmetic right shift replicates the sign; arithmetic left is the
    // same as logical left.
    always_comb begin
        logic [MAX_WIDTH-1:0] ext;
        ext              = '0;
        ext[WIDTH-1:0]   = in_data;
        in_rev_full      = bit_reverse(ext, WIDTH);
        st_data[0]       = (in_dir == DIR_LEFT) ? in_rev_full[WIDTH-1:0] : in_data;
        st_shamt[0]      = in_shamt;
        st_dir[0]        = in_dir;
        st_mode[0]       = in_mode;
        st_fill[0]       = (in_mode == MODE_ARITH && in_dir == DIR_RIGHT) ? in_data[WIDTH-1] : 1'b0;
        st_valid[0]      = in_valid;
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .src_data    (st_data[k]),
            .src_shamt   (st_shamt[k]),
            .src_dir     (st_dir[k]),
            .src_mode    (st_mode[k]),
            .src_fill    (st_fill[k]),
            .src_valid   (st_valid[k]),
            .stage_data  (st_data[k+1]),
            .stage_shamt (st_shamt[k+1]),
            .stage_dir   (st_dir[k+1]),
            .stage_mode  (st_mode[k+1]),
            .stage_fill  (st_fill[k+1]),
            .stage_valid (st_valid[k+1])
        );
    end

    // Undo the input mirroring for left shifts. The result is forced to zero
    // while no result is valid so the unreset payload never leaks out.
    always_comb begin
        logic [MAX_WIDTH-1:0] ext;
        ext            = '0;
        ext[WIDTH-1:0] = st_data[SHW];
        out_rev_full   = bit_reverse(ext, WIDTH);
        result         = (st_dir[SHW] == DIR_LEFT) ? out_rev_full[WIDTH-1:0] : st_data[SHW];
        out_data       = out_valid ? result : '0;
    end

    // The last stage's control fields and the zero-padded top of the
    // mirrored vectors have no consumers.
    logic unused_tail;
    assign unused_tail = ^{st_shamt[SHW], st_mode[SHW], st_fill[SHW]};

    if (WIDTH < MAX_WIDTH) begin : g_unused_rev
        logic unused_rev_hi;
        assign unused_rev_hi = ^{in_rev_full[MAX_WIDTH-1:WIDTH], out_rev_full[MAX_WIDTH-1:WIDTH]};
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined bidirectional shifter for the datapath ALU, the next generation after the 8-bit combinational mux-ladder shifter.
- Supports logical, arithmetic and rotate modes over a WIDTH-bit operand.
- Places one register level per shift stage (log2(WIDTH) stages) and wraps them in a valid/ready handshake with full-pipeline stall on backpressure.

Parameters:
- WIDTH, 32, operand width in bits. Must be a power of two, ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/control presented this cycle.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_dir  input  1  1 = left, 0 = right.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous active-low: assertion immediately clears all stage valid bits. Data registers need no reset.
  - Reset values: out_valid = 0, out_data = 0, in_ready = 1 once rst_n is deasserted.
- Pipeline:
  - SHW register stages, S0..S(SHW-1).
  - Stage k shifts right by 2^(SHW-1-k) when its carried shamt bit is set.
  - Each stage register carries: data, remaining shamt bits, dir, mode, fill bit, valid.
- Input conditioning (combinational before S0):
  - If in_dir = 1, bit-reverse in_data.
  - Fill bit = in_data[WIDTH-1] when mode = arithmetic and dir = right; otherwise 0.
- Stage operation:
  - Logical/arithmetic: vacated MSBs take the fill bit.
  - Rotate: vacated MSBs take the bits shifted out of the LSB end.
- Output conditioning (combinational after the last stage): bit-reverse again if the carried dir = 1.
  - out_data is driven directly from that logic, so it is stable while out_valid is held.
- Latency: SHW cycles from the accepting edge (in_valid & in_ready) to out_valid = 1, when there is no stall. Throughput is one result per cycle.
- Handshake:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en.
  - All stages advance only when en = 1; when en = 0, every stage holds data and valid.
  - Bubbles are not collapsed.
  - An input is captured only when in_valid & en.
  - out_valid, once high, stays high with constant out_data until out_ready = 1.
- Boundary conditions:
  - shamt = 0: output equals input in every mode and direction.
  - shamt = WIDTH-1, logical: a single surviving bit.
  - Arithmetic left equals logical left.
  - Rotate by k left equals rotate by WIDTH-k right.
  - Mode 11 produces the logical result.
  - Simultaneous input accept and output drain in the same cycle is legal and gives full throughput.
  - Reset mid-operation: all in-flight results are discarded. The first accept after reset release behaves as after power-up.

Decomposition:
- Shared package: mode encodings (MODE_LOGICAL, MODE_ARITH, MODE_ROTATE, MODE_RSVD), DIR_LEFT/DIR_RIGHT constants, and a bit-reverse function.
- One natural sub-module: shift_stage, parametrised by WIDTH and a DIST value.
  - It holds one registered right-shift level with fill/rotate selection and enable.
  - It is instantiated SHW times through a generate loop.

Test Plan:
- WIDTH=8, out_ready=1: in_data=8'b1011_0110, shamt=3, dir=right, mode=logical → out_data=8'b0001_0110, out_valid exactly 3 cycles after the accepting edge.
- WIDTH=8: in_data=8'h96, shamt=2, right, arithmetic → 8'hE5; same operand with dir=left, arithmetic → 8'h58.
- WIDTH=32, rotate: in_data=32'h8000_0001, shamt=4, left → 32'h0000_0018; right → 32'h1800_0000; shamt=0 in all modes → unchanged.
- Backpressure, WIDTH=8: stream 5 back-to-back operands and hold out_ready=0 for 4 cycles once the first result appears → in_ready=0 and out_data/out_valid held constant during the hold; all 5 results delivered in order with none lost or duplicated.
- Reset mid-flight: accept 2 operands, assert rst_n=0 asynchronously between clock edges → out_valid drops immediately with no clock edge; after release no stale result appears and a new operand returns after SHW cycles.
- Randomised sweep, WIDTH=16: 10k operands with random mode/dir/shamt and random out_ready compared against a behavioural model → zero mismatches; mode 11 matches logical.
